w_burst_aligner: RTL



---
 rtl/w_burst_aligner.sv | 128 ++++++++++++
 1 files changed

// File: rtl/w_burst_aligner.sv
// w_burst_aligner: frames AXI3 W beats against an in-order queue of accepted AW bursts and regenerates wlast.
// Optional macro STRICT_ID_EN holds any W beat whose wid differs from the head awid instead of forwarding it.
module w_burst_aligner #(
  parameter int ID_W   = 4,
  parameter int DATA_W = 32,
  parameter int LEN_W  = 4,
  parameter int DEPTH  = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    s_awvalid,
  output logic                    s_awready,
  input  logic [ID_W-1:0]         s_awid,
  input  logic [LEN_W-1:0]        s_awlen,
  output logic                    m_awvalid,
  input  logic                    m_awready,
  input  logic                    s_wvalid,
  output logic                    s_wready,
  input  logic [ID_W-1:0]         s_wid,
  input  logic [DATA_W-1:0]       s_wdata,
  input  logic [DATA_W/8-1:0]     s_wstrb,
  input  logic                    s_wlast,
  output logic                    m_wvalid,
  input  logic                    m_wready,
  output logic [ID_W-1:0]         m_wid,
  output logic [DATA_W-1:0]       m_wdata,
  output logic [DATA_W/8-1:0]     m_wstrb,
  output logic                    m_wlast,
  output logic [$clog2(DEPTH):0]  occupancy,
  output logic                    err_id,
  output logic                    err_last,
  output logic                    err_sticky
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [ID_W-1:0]  id_mem  [DEPTH];
  logic [LEN_W-1:0] len_mem [DEPTH];
  logic [PTR_W:0]   wr_ptr;
  logic [PTR_W:0]   rd_ptr;
  logic [LEN_W-1:0] cnt;
  logic [ID_W-1:0]  head_id;
  logic [LEN_W-1:0] head_len;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;
  logic             w_hs;
  logic             id_match;
  logic             fwd_ok;
  logic             err_id_next;
  logic             err_last_next;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign occupancy = wr_ptr - rd_ptr;
  assign empty     = (wr_ptr == rd_ptr);
  assign full      = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                     (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);

  assign head_id  = id_mem[rd_ptr[PTR_W-1:0]];
  assign head_len = len_mem[rd_ptr[PTR_W-1:0]];
  assign id_match = (s_wid == head_id);

  assign m_awvalid = s_awvalid & ~full;
  assign s_awready = m_awready & ~full;
  assign push      = m_awvalid & m_awready;

`ifdef STRICT_ID_EN
  logic stalled;
  logic stalled_q;

  assign fwd_ok      = ~empty & id_match;
  assign stalled     = s_wvalid & ~empty & ~id_match;
  assign err_id_next = stalled & ~stalled_q;
`else
  assign fwd_ok      = ~empty;
  assign err_id_next = w_hs & ~id_match;
`endif

  assign m_wvalid = s_wvalid & fwd_ok;
  assign s_wready = m_wready & fwd_ok;
  assign w_hs     = m_wvalid & m_wready;
  assign m_wid    = s_wid;
  assign m_wdata  = s_wdata;
  assign m_wstrb  = s_wstrb;

  // Framing comes only from the counter; the upstream wlast is merely compared against it.
  assign m_wlast       = ~empty & (cnt == head_len);
  assign pop           = w_hs & m_wlast;
  assign err_last_next = w_hs & (s_wlast != m_wlast);

  always_ff @(posedge clk) begin
    if (push) begin
      id_mem[wr_ptr[PTR_W-1:0]]  <= s_awid;
      len_mem[wr_ptr[PTR_W-1:0]] <= s_awlen;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      cnt        <= '0;
      err_id     <= 1'b0;
      err_last   <= 1'b0;
      err_sticky <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
        cnt    <= '0;
      end else if (w_hs) begin
        cnt <= cnt + 1'b1;
      end
      err_id     <= err_id_next;
      err_last   <= err_last_next;
      err_sticky <= err_sticky | err_id_next | err_last_next;
    end
  end

`ifdef STRICT_ID_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) stalled_q <= 1'b0;
    else     stalled_q <= stalled;
  end
`endif

endmodule
